// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
package bin2bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

endpackage

// File: rtl/add_3.sv
// rtl/add_3.sv - double-dabble digit correction cell: 5..9 gets +3, below 5 passes through
module add_3
    import bin2bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t corrected
);

    // Inputs 10..15 never occur inside a conversion; they still add 3 rather than saturate.
    assign corrected = (digit >= bcd_digit_t'(5)) ? digit + bcd_digit_t'(3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD, one shift per clock; BCD_OVF_EN adds a sticky overflow output
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      ready,
    output logic                      done_tick,
`ifdef BCD_OVF_EN
    output logic                      overflow,
`endif
    output logic [DIGIT_W*DIGITS-1:0] bcd
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   work;
    logic [BCD_W-1:0]   corr;
    logic [BCD_W-1:0]   work_nxt;
    logic               accept;
    logic               last;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            add_3 u_add_3 (
                .digit     (work[g*DIGIT_W +: DIGIT_W]),
                .corrected (corr[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Top bit of the corrected digits falls off; the binary MSB enters the ones digit.
    assign work_nxt = {corr[BCD_W-2:0], shreg[BIN_W-1]};
    assign accept   = (state == IDLE) && start;
    assign last     = (state == OP) && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done_tick = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = OP;
                end
            end
            OP: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_tick = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // bcd is loaded on the final shift so it is already valid while done_tick is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            work  <= '0;
            cnt   <= '0;
            bcd   <= '0;
        end else if (accept) begin
            shreg <= bin;
            work  <= '0;
            cnt   <= CNT_W'(BIN_W);
        end else if (state == OP) begin
            shreg <= {shreg[BIN_W-2:0], 1'b0};
            work  <= work_nxt;
            cnt   <= cnt - CNT_W'(1);
            if (last) begin
                bcd <= work_nxt;
            end
        end
    end

`ifdef BCD_OVF_EN
    logic ovf_sticky;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_sticky <= 1'b0;
            overflow   <= 1'b0;
        end else if (accept) begin
            ovf_sticky <= 1'b0;
        end else if (state == OP) begin
            ovf_sticky <= ovf_sticky | corr[BCD_W-1];
            if (last) begin
                overflow <= ovf_sticky | corr[BCD_W-1];
            end
        end
    end
`endif

endmodule
